// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: legal DQ widths, bank limits and small helpers
// used by the datapath and the per-bank sequencers.
package sdram_pkg;

  localparam int DQ_W_16      = 16;
  localparam int DQ_W_32      = 32;
  localparam int NB_BANKS_MAX = 8;

  function automatic int byte_lanes(input int dq_w);
    return dq_w / 8;
  endfunction

  function automatic logic onehot_multi(input logic [NB_BANKS_MAX-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < NB_BANKS_MAX; i++) begin
      if (vec[i]) cnt++;
    end
    return (cnt > 1);
  endfunction

endpackage

// File: rtl/sdram_delay_line.sv
// Fixed-depth shift register with asynchronous clear; used for the write
// fetch delay and the read-tag pipeline.
module sdram_delay_line
  import sdram_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sdram_data_path.sv
// SDRAM DQ/DQM datapath: muxes per-bank write data onto the pins after WR_LAT
// cycles and tags captured read data with the issuing bank after CAS latency.
module sdram_data_path
  import sdram_pkg::*;
#(
  parameter int  DQ_W     = 16,
  parameter int  NB_BANKS = 4,
  parameter int  WR_LAT   = 4,
  parameter int  CAS_LAT  = 2,
  parameter real TCO_DLY  = 4.5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NB_BANKS-1:0]        data_fetch,
  input  logic [NB_BANKS*DQ_W/8-1:0] wr_bena,
  input  logic [NB_BANKS*DQ_W-1:0]   wr_data,
  input  logic [NB_BANKS-1:0]        rd_issue,
  output logic [DQ_W-1:0]            rd_data,
  output logic [NB_BANKS-1:0]        rd_valid,
  output logic                       err_multi,
  output logic                       err_bus,
  output logic [DQ_W/8-1:0]          sdram_dqm_n,
  output logic                       sdram_dq_oe,
  output logic [DQ_W-1:0]            sdram_dq_o,
  input  logic [DQ_W-1:0]            sdram_dq_i
);

  localparam int NL   = byte_lanes(DQ_W);
  localparam int HALF = (NB_BANKS > 2) ? NB_BANKS / 2 : NB_BANKS;

  if (DQ_W != DQ_W_16 && DQ_W != DQ_W_32) begin : g_bad_dq_w
    $error("sdram_data_path: DQ_W must be 16 or 32");
  end
  if (NB_BANKS < 1 || NB_BANKS > NB_BANKS_MAX) begin : g_bad_banks
    $error("sdram_data_path: NB_BANKS must be 1..8");
  end
  if (WR_LAT < 3) begin : g_bad_wr_lat
    $error("sdram_data_path: WR_LAT must be at least 3");
  end
  if (CAS_LAT != 2 && CAS_LAT != 3) begin : g_bad_cas_lat
    $error("sdram_data_path: CAS_LAT must be 2 or 3");
  end
  // Pin delay is modelled by the board/timing environment, not here.
  if (TCO_DLY < 0.0) begin : g_bad_tco
    $error("sdram_data_path: TCO_DLY must not be negative");
  end

  logic [NB_BANKS-1:0]     fe;
  logic [NB_BANKS-1:0]     tag_now;
  logic [NB_BANKS_MAX-1:0] fetch_ext;
  logic [NB_BANKS_MAX-1:0] issue_ext;
  logic [DQ_W-1:0]         data_lo, data_hi, sel_data, sel_data_q;
  logic [NL-1:0]           bena_lo, bena_hi, sel_mask, sel_mask_q;
  logic                    sel_oe, sel_oe_q;

  sdram_delay_line #(.WIDTH(NB_BANKS), .DEPTH(WR_LAT-2)) u_fetch_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (data_fetch),
    .dout (fe)
  );

  // Tag stage CAS_LAT lines up with the data on the pins this cycle;
  // rd_valid is one more register so it meets the registered rd_data.
  sdram_delay_line #(.WIDTH(NB_BANKS), .DEPTH(CAS_LAT)) u_tag_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_issue),
    .dout (tag_now)
  );

  // AND-OR select, split into two OR trees that meet in a final OR.
  always_comb begin
    data_lo = '0;
    data_hi = '0;
    bena_lo = '0;
    bena_hi = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      if (b < HALF) begin
        data_lo = data_lo | (wr_data[b*DQ_W +: DQ_W] & {DQ_W{fe[b]}});
        bena_lo = bena_lo | (wr_bena[b*NL +: NL] & {NL{fe[b]}});
      end else begin
        data_hi = data_hi | (wr_data[b*DQ_W +: DQ_W] & {DQ_W{fe[b]}});
        bena_hi = bena_hi | (wr_bena[b*NL +: NL] & {NL{fe[b]}});
      end
    end
    sel_data = data_lo | data_hi;
    sel_oe   = |fe;
    sel_mask = sel_oe ? ~(bena_lo | bena_hi) : '0;
  end

  always_comb begin
    fetch_ext = '0;
    issue_ext = '0;
    fetch_ext[NB_BANKS-1:0] = data_fetch;
    issue_ext[NB_BANKS-1:0] = rd_issue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_data_q  <= '0;
      sel_mask_q  <= '0;
      sel_oe_q    <= 1'b0;
      sdram_dq_o  <= '0;
      sdram_dqm_n <= '0;
      sdram_dq_oe <= 1'b0;
    end else begin
      sel_data_q  <= sel_data;
      sel_mask_q  <= sel_mask;
      sel_oe_q    <= sel_oe;
      sdram_dq_o  <= sel_data_q;
      sdram_dqm_n <= sel_mask_q;
      sdram_dq_oe <= sel_oe_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data   <= '0;
      rd_valid  <= '0;
      err_multi <= 1'b0;
      err_bus   <= 1'b0;
    end else begin
      rd_data  <= sdram_dq_i;
      rd_valid <= tag_now;
      if (onehot_multi(fetch_ext) || onehot_multi(issue_ext)) err_multi <= 1'b1;
      if ((|tag_now) && sdram_dq_oe) err_bus <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_data_path.sv
// Scoreboard bench for sdram_data_path: a 16-bit/4-bank/WR_LAT=4/CAS=2 instance
// and a 32-bit/8-bank/WR_LAT=5/CAS=3 instance driven side by side.
module tb_sdram_data_path;

  typedef struct {
    int          cyc;
    logic [31:0] dq;
    logic [3:0]  dqm;
    logic        oe;
  } pin_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [7:0]  valid;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  pin_exp_t pa_q[$];
  pin_exp_t pb_q[$];
  rd_exp_t  ra_q[$];
  rd_exp_t  rb_q[$];

  logic [3:0]  a_data_fetch, a_rd_issue, a_rd_valid;
  logic [7:0]  a_wr_bena;
  logic [63:0] a_wr_data;
  logic [15:0] a_rd_data, a_dq_o, a_dq_i;
  logic [1:0]  a_dqm_n;
  logic        a_err_multi, a_err_bus, a_dq_oe;

  logic [7:0]   b_data_fetch, b_rd_issue, b_rd_valid;
  logic [31:0]  b_wr_bena;
  logic [255:0] b_wr_data;
  logic [31:0]  b_rd_data, b_dq_o, b_dq_i;
  logic [3:0]   b_dqm_n;
  logic         b_err_multi, b_err_bus, b_dq_oe;

  sdram_data_path #(.DQ_W(16), .NB_BANKS(4), .WR_LAT(4), .CAS_LAT(2)) dut_a (
    .clk(clk), .rst(rst), .data_fetch(a_data_fetch), .wr_bena(a_wr_bena),
    .wr_data(a_wr_data), .rd_issue(a_rd_issue), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .err_multi(a_err_multi), .err_bus(a_err_bus),
    .sdram_dqm_n(a_dqm_n), .sdram_dq_oe(a_dq_oe), .sdram_dq_o(a_dq_o),
    .sdram_dq_i(a_dq_i)
  );

  sdram_data_path #(.DQ_W(32), .NB_BANKS(8), .WR_LAT(5), .CAS_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .data_fetch(b_data_fetch), .wr_bena(b_wr_bena),
    .wr_data(b_wr_data), .rd_issue(b_rd_issue), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .err_multi(b_err_multi), .err_bus(b_err_bus),
    .sdram_dqm_n(b_dqm_n), .sdram_dq_oe(b_dq_oe), .sdram_dq_o(b_dq_o),
    .sdram_dq_i(b_dq_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle_inputs();
    a_data_fetch = '0; a_wr_bena = '0; a_wr_data = '0; a_rd_issue = '0; a_dq_i = '0;
    b_data_fetch = '0; b_wr_bena = '0; b_wr_data = '0; b_rd_issue = '0; b_dq_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    a_dq_i = 16'hFFFF;
    b_dq_i = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_dq_oe, a_dqm_n, a_dq_o, a_rd_data, a_rd_valid, a_err_multi, a_err_bus} !== '0) begin
      errors++;
      $display("FAIL reset_a got oe=%b dqm=%b dq=%h rd=%h v=%b em=%b eb=%b want all zero",
               a_dq_oe, a_dqm_n, a_dq_o, a_rd_data, a_rd_valid, a_err_multi, a_err_bus);
    end
    checks++;
    if ({b_dq_oe, b_dqm_n, b_dq_o, b_rd_data, b_rd_valid, b_err_multi, b_err_bus} !== '0) begin
      errors++;
      $display("FAIL reset_b got oe=%b dqm=%b dq=%h rd=%h v=%b em=%b eb=%b want all zero",
               b_dq_oe, b_dqm_n, b_dq_o, b_rd_data, b_rd_valid, b_err_multi, b_err_bus);
    end
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_write();
    int t0;
    pin_exp_t e;
    @(posedge clk); #1;
    t0 = cyc;
    pa_q.push_back('{t0+4, 32'h0000_A5C3, 4'b0010, 1'b1});
    pa_q.push_back('{t0+5, 32'h0, 4'b0000, 1'b0});
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      idle_inputs();
      if (k == 0) a_data_fetch = 4'b0010;
      if (k == 2) begin
        a_wr_data[16 +: 16] = 16'hA5C3;
        a_wr_bena[2 +: 2]   = 2'b01;
        a_wr_data[0 +: 16]  = 16'hFFFF;
        a_wr_bena[0 +: 2]   = 2'b11;
      end
      @(negedge clk);
      while (pa_q.size() > 0 && pa_q[0].cyc <= cyc) begin
        e = pa_q.pop_front();
        checks++;
        if ({a_dq_oe, a_dqm_n, a_dq_o} !== {e.oe, e.dqm[1:0], e.dq[15:0]}) begin
          errors++;
          $display("FAIL single_write p%0d got oe=%b dqm=%b dq=%h want oe=%b dqm=%b dq=%h",
                   cyc-t0, a_dq_oe, a_dqm_n, a_dq_o, e.oe, e.dqm[1:0], e.dq[15:0]);
        end
      end
    end
    if (pa_q.size() != 0) begin
      errors++;
      $display("FAIL single_write timeout got %0d pending want 0", pa_q.size());
      pa_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    pin_exp_t e;
    @(posedge clk); #1;
    t0 = cyc;
    pa_q.push_back('{t0+4, 32'h0000_1111, 4'b0000, 1'b1});
    pa_q.push_back('{t0+5, 32'h0000_3333, 4'b0000, 1'b1});
    pa_q.push_back('{t0+6, 32'h0, 4'b0000, 1'b0});
    pb_q.push_back('{t0+5, 32'h1111_1111, 4'b0000, 1'b1});
    pb_q.push_back('{t0+6, 32'h3333_3333, 4'b0000, 1'b1});
    pb_q.push_back('{t0+7, 32'h0, 4'b0000, 1'b0});
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      idle_inputs();
      case (k)
        0: begin a_data_fetch = 4'b0001; b_data_fetch = 8'h01; end
        1: begin a_data_fetch = 4'b1000; b_data_fetch = 8'h08; end
        2: begin a_wr_data[0 +: 16] = 16'h1111; a_wr_bena[0 +: 2] = 2'b11; end
        3: begin
          a_wr_data[48 +: 16] = 16'h3333; a_wr_bena[6 +: 2] = 2'b11;
          b_wr_data[0 +: 32] = 32'h1111_1111; b_wr_bena[0 +: 4] = 4'hF;
        end
        4: begin b_wr_data[96 +: 32] = 32'h3333_3333; b_wr_bena[12 +: 4] = 4'hF; end
        default: ;
      endcase
      @(negedge clk);
      while (pa_q.size() > 0 && pa_q[0].cyc <= cyc) begin
        e = pa_q.pop_front();
        checks++;
        if ({a_dq_oe, a_dqm_n, a_dq_o} !== {e.oe, e.dqm[1:0], e.dq[15:0]}) begin
          errors++;
          $display("FAIL b2b_a p%0d got oe=%b dqm=%b dq=%h want oe=%b dqm=%b dq=%h",
                   cyc-t0, a_dq_oe, a_dqm_n, a_dq_o, e.oe, e.dqm[1:0], e.dq[15:0]);
        end
      end
      while (pb_q.size() > 0 && pb_q[0].cyc <= cyc) begin
        e = pb_q.pop_front();
        checks++;
        if ({b_dq_oe, b_dqm_n, b_dq_o} !== {e.oe, e.dqm, e.dq}) begin
          errors++;
          $display("FAIL b2b_b p%0d got oe=%b dqm=%b dq=%h want oe=%b dqm=%b dq=%h",
                   cyc-t0, b_dq_oe, b_dqm_n, b_dq_o, e.oe, e.dqm, e.dq);
        end
      end
    end
    if (pa_q.size() + pb_q.size() != 0) begin
      errors++;
      $display("FAIL b2b timeout got %0d pending want 0", pa_q.size() + pb_q.size());
      pa_q.delete();
      pb_q.delete();
    end
  endtask

  task automatic test_read_tag();
    int t0;
    rd_exp_t e;
    @(posedge clk); #1;
    t0 = cyc;
    ra_q.push_back('{t0+2, 32'h0, 8'h00});
    ra_q.push_back('{t0+3, 32'h0000_BEEF, 8'h04});
    ra_q.push_back('{t0+4, 32'h0, 8'h00});
    ra_q.push_back('{t0+8, 32'h0000_1234, 8'h02});
    ra_q.push_back('{t0+9, 32'h0000_5678, 8'h08});
    ra_q.push_back('{t0+10, 32'h0, 8'h00});
    rb_q.push_back('{t0+3, 32'h0, 8'h00});
    rb_q.push_back('{t0+4, 32'hCAFE_F00D, 8'h04});
    rb_q.push_back('{t0+5, 32'h0, 8'h00});
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      idle_inputs();
      case (k)
        0: begin a_rd_issue = 4'b0100; b_rd_issue = 8'h04; end
        2: a_dq_i = 16'hBEEF;
        3: b_dq_i = 32'hCAFE_F00D;
        5: a_rd_issue = 4'b0010;
        6: a_rd_issue = 4'b1000;
        7: a_dq_i = 16'h1234;
        8: a_dq_i = 16'h5678;
        default: ;
      endcase
      @(negedge clk);
      while (ra_q.size() > 0 && ra_q[0].cyc <= cyc) begin
        e = ra_q.pop_front();
        checks++;
        if ({a_rd_valid, a_rd_data} !== {e.valid[3:0], e.data[15:0]}) begin
          errors++;
          $display("FAIL read_a c%0d got valid=%b data=%h want valid=%b data=%h",
                   cyc-t0, a_rd_valid, a_rd_data, e.valid[3:0], e.data[15:0]);
        end
      end
      while (rb_q.size() > 0 && rb_q[0].cyc <= cyc) begin
        e = rb_q.pop_front();
        checks++;
        if ({b_rd_valid, b_rd_data} !== {e.valid, e.data}) begin
          errors++;
          $display("FAIL read_b c%0d got valid=%b data=%h want valid=%b data=%h",
                   cyc-t0, b_rd_valid, b_rd_data, e.valid, e.data);
        end
      end
    end
    if (ra_q.size() + rb_q.size() != 0) begin
      errors++;
      $display("FAIL read timeout got %0d pending want 0", ra_q.size() + rb_q.size());
      ra_q.delete();
      rb_q.delete();
    end
  endtask

  task automatic test_wide_mask();
    int t0;
    pin_exp_t e;
    @(posedge clk); #1;
    t0 = cyc;
    pb_q.push_back('{t0+5, 32'hDEAD_BEEF, 4'b0110, 1'b1});
    pb_q.push_back('{t0+6, 32'h0, 4'b0000, 1'b0});
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      idle_inputs();
      if (k == 0) b_data_fetch = 8'h80;
      if (k == 3) begin
        b_wr_data[224 +: 32] = 32'hDEAD_BEEF;
        b_wr_bena[28 +: 4]   = 4'b1001;
        b_wr_data[192 +: 32] = 32'hFFFF_FFFF;
        b_wr_bena[24 +: 4]   = 4'hF;
      end
      @(negedge clk);
      while (pb_q.size() > 0 && pb_q[0].cyc <= cyc) begin
        e = pb_q.pop_front();
        checks++;
        if ({b_dq_oe, b_dqm_n, b_dq_o} !== {e.oe, e.dqm, e.dq}) begin
          errors++;
          $display("FAIL wide_mask p%0d got oe=%b dqm=%b dq=%h want oe=%b dqm=%b dq=%h",
                   cyc-t0, b_dq_oe, b_dqm_n, b_dq_o, e.oe, e.dqm, e.dq);
        end
      end
    end
    if (pb_q.size() != 0) begin
      errors++;
      $display("FAIL wide_mask timeout got %0d pending want 0", pb_q.size());
      pb_q.delete();
    end
  endtask

  task automatic test_conflict();
    int t0;
    pin_exp_t e;
    @(posedge clk); #1;
    t0 = cyc;
    pa_q.push_back('{t0+4, 32'h0000_0FF0, 4'b0000, 1'b1});
    pa_q.push_back('{t0+5, 32'h0, 4'b0000, 1'b0});
    pa_q.push_back('{t0+14, 32'h0000_7777, 4'b0000, 1'b1});
    pa_q.push_back('{t0+15, 32'h0, 4'b0000, 1'b0});
    for (int k = 0; k < 18; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      idle_inputs();
      case (k)
        0: a_data_fetch = 4'b0011;
        2: begin
          a_wr_data[0 +: 16]  = 16'h00F0; a_wr_bena[0 +: 2] = 2'b01;
          a_wr_data[16 +: 16] = 16'h0F00; a_wr_bena[2 +: 2] = 2'b10;
        end
        10: a_data_fetch = 4'b0100;
        12: begin
          a_rd_issue = 4'b0001;
          a_wr_data[32 +: 16] = 16'h7777; a_wr_bena[4 +: 2] = 2'b11;
        end
        default: ;
      endcase
      @(negedge clk);
      if (k == 0 || k == 1 || k == 9) begin
        checks++;
        if (a_err_multi !== (k != 0)) begin
          errors++;
          $display("FAIL err_multi c%0d got %b want %b", k, a_err_multi, (k != 0));
        end
      end
      if (k == 14 || k == 15 || k == 17) begin
        checks++;
        if (a_err_bus !== (k != 14)) begin
          errors++;
          $display("FAIL err_bus c%0d got %b want %b", k, a_err_bus, (k != 14));
        end
      end
      if (k == 15) begin
        checks++;
        if (a_rd_valid !== 4'b0001) begin
          errors++;
          $display("FAIL conflict_rd_valid got %b want 0001", a_rd_valid);
        end
      end
      while (pa_q.size() > 0 && pa_q[0].cyc <= cyc) begin
        e = pa_q.pop_front();
        checks++;
        if ({a_dq_oe, a_dqm_n, a_dq_o} !== {e.oe, e.dqm[1:0], e.dq[15:0]}) begin
          errors++;
          $display("FAIL conflict_pins p%0d got oe=%b dqm=%b dq=%h want oe=%b dqm=%b dq=%h",
                   cyc-t0, a_dq_oe, a_dqm_n, a_dq_o, e.oe, e.dqm[1:0], e.dq[15:0]);
        end
      end
    end
    if (pa_q.size() != 0) begin
      errors++;
      $display("FAIL conflict timeout got %0d pending want 0", pa_q.size());
      pa_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin @(posedge clk); end
      #1;
      idle_inputs();
      if (k == 0) a_data_fetch = 4'b0100;
      if (k == 2) begin
        a_wr_data[32 +: 16] = 16'h5555;
        a_wr_bena[4 +: 2]   = 2'b11;
        rst = 1'b1;
        #1;
        checks++;
        if ({a_dq_oe, a_dqm_n, a_dq_o, a_rd_valid, a_err_multi, a_err_bus} !== '0) begin
          errors++;
          $display("FAIL reset_mid got oe=%b dqm=%b dq=%h v=%b em=%b eb=%b want all zero",
                   a_dq_oe, a_dqm_n, a_dq_o, a_rd_valid, a_err_multi, a_err_bus);
        end
      end
      @(negedge clk);
      if (k == 2) rst = 1'b0;
      if (k >= 3) begin
        checks++;
        if (a_dq_oe !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_oe c%0d got %b want 0", k, a_dq_oe);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read_tag();
    test_wide_mask();
    test_conflict();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
